// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-through, no-write-allocate data cache
//               controller. Each line holds one 16-bit word. The optional
//               statistics counters are enabled by defining DCACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        CacheReq,
  output logic        err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] req_count
`endif
);

  localparam int C_LINES = 2 ** INDEX_BITS;
  localparam int C_TAG_W = 16 - INDEX_BITS - 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_MISS = 2'd1;
  localparam logic [1:0] S_WR_THRU = 2'd2;

  logic [1:0]               r_state;
  logic [C_LINES-1:0]       r_valid;
  logic [C_TAG_W-1:0]       r_tag  [C_LINES];
  logic [15:0]              r_data [C_LINES];
  logic [15:0]              r_addr;
  logic [15:0]              r_wdata;

  logic                     w_idle;
  logic                     w_busy;
  logic [INDEX_BITS-1:0]    w_idx;
  logic [C_TAG_W-1:0]       w_tag;
  logic [INDEX_BITS-1:0]    w_fill_idx;
  logic [C_TAG_W-1:0]       w_fill_tag;
  logic                     w_err;
  logic                     w_valid_req;
  logic                     w_hit;
  logic                     w_rd_hit;
  logic                     w_wr_hit;
  logic                     w_fill;

  assign w_idle     = (r_state == S_IDLE);
  assign w_busy     = (r_state == S_RD_MISS) || (r_state == S_WR_THRU);
  assign w_idx      = Addr[INDEX_BITS:1];
  assign w_tag      = Addr[15:INDEX_BITS+1];
  assign w_fill_idx = r_addr[INDEX_BITS:1];
  assign w_fill_tag = r_addr[15:INDEX_BITS+1];

  // Request decode is gated by rst so every output reads 0 while reset is held.
  assign w_err       = !rst && w_idle && ((Rd && Wr) || (Addr[0] && (Rd || Wr)));
  assign w_valid_req = !rst && w_idle && (Rd ^ Wr) && !Addr[0];
  assign w_hit       = w_valid_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rd_hit    = w_hit && Rd;
  assign w_wr_hit    = w_hit && Wr;
  assign w_fill      = (r_state == S_RD_MISS) && mem_ack;

  assign err       = w_err;
  assign CacheReq  = w_valid_req;
  assign CacheHit  = w_hit;
  assign Done      = w_rd_hit || (w_busy && mem_ack);
  assign Stall     = (w_valid_req && !w_rd_hit) || (w_busy && !mem_ack);
  assign mem_req   = w_busy;
  assign mem_wr    = (r_state == S_WR_THRU);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  always_comb begin
    DataOut = 16'h0000;
    if (w_rd_hit) begin
      DataOut = r_data[w_idx];
    end else if (w_fill) begin
      DataOut = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_valid_req && Wr) begin
            r_addr  <= Addr;
            r_wdata <= DataIn;
            r_state <= S_WR_THRU;
          end else if (w_valid_req && !w_hit) begin
            r_addr  <= Addr;
            r_state <= S_RD_MISS;
          end
        end
        S_RD_MISS: if (mem_ack) r_state <= S_IDLE;
        S_WR_THRU: if (mem_ack) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      r_data[w_idx] <= DataIn;
    end
    if (w_fill) begin
      r_data[w_fill_idx] <= mem_rdata;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_req_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count <= 16'h0000;
      r_req_count <= 16'h0000;
    end else begin
      if (w_hit && (r_hit_count != 16'hFFFF)) r_hit_count <= r_hit_count + 16'd1;
      if (w_valid_req && (r_req_count != 16'hFFFF)) r_req_count <= r_req_count + 16'd1;
    end
  end

  assign hit_count = r_hit_count;
  assign req_count = r_req_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl: directed scenarios plus
//               randomized loads/stores against a line-level cache model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  localparam int INDEX_BITS = 5;
  localparam int LINES      = 2 ** INDEX_BITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = '0;
  logic [15:0] DataIn = '0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, CacheReq, err;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, req_count;
`endif

  dcache_ctrl #(.INDEX_BITS(INDEX_BITS)) u_dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit),
    .CacheReq(CacheReq), .err(err), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .req_count(req_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: cache contents by line, backing store by word address
  bit          m_valid [LINES];
  int          m_tag   [LINES];
  logic [15:0] m_data  [LINES];
  logic [15:0] bmem    [int];
  int          m_hits = 0;
  int          m_reqs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    int k = int'(a >> 1);
    if (bmem.exists(k)) return bmem[k];
    return a ^ 16'h5A5A;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_reqs = 0;
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, input int lat);
    int          idx;
    int          tg;
    bit          bad;
    bit          hit;
    logic [15:0] rdv;
    idx = int'(addr >> 1) % LINES;
    tg  = int'(addr >> (INDEX_BITS + 1));
    bad = (rd && wr) || (addr[0] && (rd || wr));
    hit = m_valid[idx] && (m_tag[idx] == tg);
    @(negedge clk);
    Rd = rd; Wr = wr; Addr = addr; DataIn = wd;
    #1;
    if (bad) begin
      check("err", err, 1);
      check("err_req", CacheReq, 0);
      check("err_stall", Stall, 0);
      check("err_done", Done, 0);
      @(posedge clk); #1;
      check("err_memreq", mem_req, 0);
      Rd = 0; Wr = 0;
      return;
    end
    m_reqs++;
    if (hit) m_hits++;
    check("err_clr", err, 0);
    check("req", CacheReq, 1);
    check("hit", CacheHit, hit);
    if (rd && hit) begin
      check("hit_done", Done, 1);
      check("hit_data", DataOut, m_data[idx]);
      check("hit_stall", Stall, 0);
      @(posedge clk); #1;
      check("hit_memreq", mem_req, 0);
      Rd = 0;
      return;
    end
    check("acc_stall", Stall, 1);
    check("acc_done", Done, 0);
    @(posedge clk);
    if (wr && hit) m_data[idx] = wd;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk); #1;
      check("wait_memreq", mem_req, 1);
      check("wait_memwr", mem_wr, wr);
      check("wait_addr", mem_addr, addr);
      if (wr) check("wait_wdata", mem_wdata, wd);
      check("wait_stall", Stall, 1);
      check("wait_done", Done, 0);
      @(posedge clk);
    end
    @(negedge clk);
    rdv = mem_read(addr);
    mem_ack = 1'b1;
    mem_rdata = rd ? rdv : 16'(~rdv);
    #1;
    check("ack_memreq", mem_req, 1);
    check("ack_stall", Stall, 0);
    check("ack_done", Done, 1);
    check("ack_data", DataOut, rd ? rdv : 16'h0000);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    Rd = 0; Wr = 0;
    if (rd) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = rdv;
    end else begin
      bmem[int'(addr >> 1)] = wd;
    end
    check("post_memreq", mem_req, 0);
  endtask

  initial begin
    logic [15:0] a;
    int          sel;
    model_reset();
    #1;
    check("rst_done", Done, 0);
    check("rst_stall", Stall, 0);
    check("rst_memreq", mem_req, 0);
    check("rst_memaddr", mem_addr, 0);
    check("rst_dataout", DataOut, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    bmem[16'h0010 >> 1] = 16'hBEEF;
    do_req(1, 0, 16'h0010, 16'h0000, 4);
    do_req(1, 0, 16'h0010, 16'h0000, 1);
    do_req(0, 1, 16'h0010, 16'h1234, 2);
    do_req(1, 0, 16'h0010, 16'h0000, 1);
    do_req(0, 1, 16'h0050, 16'hCAFE, 3);
    do_req(1, 0, 16'h0050, 16'h0000, 2);
    do_req(1, 0, 16'h0010, 16'h0000, 2);
    do_req(1, 0, 16'h0011, 16'h0000, 1);
    do_req(1, 1, 16'h0020, 16'h0000, 1);

    for (int n = 0; n < 200; n++) begin
      a   = 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 1));
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      do_req(1, 0, a | 16'h0001, 16'(($urandom)), 1);
      else if (sel == 1) do_req(1, 1, a, 16'(($urandom)), 1);
      else if (sel < 11) do_req(1, 0, a, 16'h0000, int'($urandom_range(1, 4)));
      else               do_req(0, 1, a, 16'(($urandom)), int'($urandom_range(1, 4)));
    end

    // Reset during a read miss, then a stray ack while idle
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    Rd = 1; Addr = 16'h0010;
    #1;
    check("r6_stall", Stall, 1);
    @(posedge clk);
    @(negedge clk); #1;
    check("r6_memreq", mem_req, 1);
    rst = 1'b1;
    #1;
    check("r6_rst_memreq", mem_req, 0);
    check("r6_rst_stall", Stall, 0);
    check("r6_rst_addr", mem_addr, 0);
    Rd = 0;
`ifdef DCACHE_STATS_EN
    check("r6_hitcnt", hit_count, 0);
    check("r6_reqcnt", req_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    #1;
    check("late_ack_done", Done, 0);
    check("late_ack_data", DataOut, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack_memreq", mem_req, 0);
    do_req(1, 0, 16'h0010, 16'h0000, 2);
    do_req(1, 0, 16'h0010, 16'h0000, 1);
`ifdef DCACHE_STATS_EN
    #1;
    check("hitcnt", hit_count, 16'(m_hits));
    check("reqcnt", req_count, 16'(m_reqs));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
